// File: rtl/jtframe_colmix_pkg.sv
// Shared definitions for the N-layer colour mixer: palette bank codes,
// pipeline depth and a width helper usable in parameter expressions.
package jtframe_colmix_pkg;

  typedef enum logic [1:0] {
    BANK_R    = 2'd0,
    BANK_G    = 2'd1,
    BANK_B    = 2'd2,
    BANK_NONE = 2'd3
  } bank_e;

  localparam int LATENCY = 4;

  function automatic int colmix_clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/jtframe_colmix_wrbuf.sv
// One-entry posted write buffer for CPU palette writes; commits only on
// clocks where the pixel pipeline leaves the RAM port idle.
module jtframe_colmix_wrbuf
  import jtframe_colmix_pkg::*;
#(
  parameter int AW = 9,
  parameter int DW = 4
)(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_cs,
  input  logic          i_wr,
  input  logic [AW+1:0] i_addr,
  input  logic [DW-1:0] i_din,
  input  logic          i_pxl_cen,
  output logic          o_busy,
  output logic [2:0]    o_we,
  output logic [AW-1:0] o_waddr,
  output logic [DW-1:0] o_wdata
);

  // Handshake: a strobe (i_cs & i_wr) is accepted on a clock edge only while
  // o_busy is low; strobes seen while o_busy is high are dropped, so the CPU
  // must hold off until o_busy falls. Bank NONE strobes are never accepted.
  bank_e         r_bank;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;
  logic          r_full;
  logic          w_take;
  logic          w_commit;

  assign w_take   = i_cs & i_wr & ~r_full & (i_addr[AW+1:AW] != BANK_NONE);
  assign w_commit = r_full & ~i_pxl_cen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= 1'b0;
      r_bank <= BANK_R;
      r_addr <= '0;
      r_data <= '0;
    end else if (w_take) begin
      r_full <= 1'b1;
      r_bank <= bank_e'(i_addr[AW+1:AW]);
      r_addr <= i_addr[AW-1:0];
      r_data <= i_din;
    end else if (w_commit) begin
      r_full <= 1'b0;
    end
  end

  assign o_busy  = r_full;
  assign o_we[0] = w_commit & (r_bank == BANK_R);
  assign o_we[1] = w_commit & (r_bank == BANK_G);
  assign o_we[2] = w_commit & (r_bank == BANK_B);
  assign o_waddr = r_addr;
  assign o_wdata = r_data;

endmodule

// File: rtl/jtframe_prom.sv
// Priority PROM with an independent programming port. A read and a program
// write to the same address in one cycle returns the old contents.
module jtframe_prom #(
  parameter int aw = 8,
  parameter int dw = 2
)(
  input  logic          clk,
  input  logic          i_cen,
  input  logic [aw-1:0] i_rd_addr,
  output logic [dw-1:0] o_q,
  input  logic [aw-1:0] i_prog_addr,
  input  logic [dw-1:0] i_prog_data,
  input  logic          i_prog_we
);

  logic [dw-1:0] r_mem [0:(1<<aw)-1];
  logic [dw-1:0] r_q;

  always_ff @(posedge clk) begin
    if (i_prog_we) r_mem[i_prog_addr] <= i_prog_data;
    if (i_cen) r_q <= r_mem[i_rd_addr];
  end

  assign o_q = r_q;

endmodule

// File: rtl/jtframe_ram.sv
// Single-port palette RAM: reads are registered on the clock enable, writes
// land whenever i_we is high. Contents are deliberately not reset.
module jtframe_ram #(
  parameter int aw = 9,
  parameter int dw = 4
)(
  input  logic          clk,
  input  logic          i_cen,
  input  logic [aw-1:0] i_addr,
  input  logic [dw-1:0] i_data,
  input  logic          i_we,
  output logic [dw-1:0] o_q
);

  logic [dw-1:0] r_mem [0:(1<<aw)-1];
  logic [dw-1:0] r_q;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_data;
    if (i_cen) r_q <= r_mem[i_addr];
  end

  assign o_q = r_q;

endmodule

// File: rtl/jtdd_colmix_nlayer.sv
// N-layer colour mixer: transparency flags -> priority PROM -> palette RAMs
// -> blanked RGB, four pixel-enable ticks from pixel input to colour output.
module jtdd_colmix_nlayer
  import jtframe_colmix_pkg::*;
#(
  parameter int             LAYERS = 4,
  parameter int             PXLW   = 7,
  parameter int             TRW    = 4,
  parameter logic [TRW-1:0] TRANSP = 4'hF,
  parameter int             PRIOAW = 8,
  parameter int             COLW   = 4,
  localparam int            LW     = colmix_clog2(LAYERS),
  localparam int            PALAW  = LW + PXLW
)(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pxl_cen,
  input  logic                   lhbl,
  input  logic                   lvbl,
  input  logic [LAYERS*PXLW-1:0] pxl_in,
  input  logic [7:0]             cpu_dout,
  input  logic [PALAW+1:0]       cpu_addr,
  input  logic                   pal_cs,
  input  logic                   cpu_wr,
  output logic                   pal_busy,
  input  logic [PRIOAW-1:0]      prog_addr,
  input  logic [LW-1:0]          prog_din,
  input  logic                   prom_prio_we,
  output logic [COLW-1:0]        red,
  output logic [COLW-1:0]        green,
  output logic [COLW-1:0]        blue,
  output logic                   lhbl_dly,
  output logic                   lvbl_dly
);

  localparam int TOPW = PRIOAW - LAYERS;

  logic [LAYERS*PXLW-1:0] r_pxl0, r_pxl1;
  logic [LAYERS-1:0]      r_opq;
  logic [LATENCY-2:0]     r_hb, r_vb;
  logic                   r_bad3;
  logic [COLW-1:0]        r_red, r_green, r_blue;
  logic                   r_lhbl_dly, r_lvbl_dly;

  logic [PRIOAW-1:0]      w_prom_addr;
  logic [LW-1:0]          w_sel;
  logic [PXLW-1:0]        w_pix;
  logic                   w_bad;
  logic [PALAW-1:0]       w_ram_addr;
  logic [PALAW-1:0]       w_waddr;
  logic [COLW-1:0]        w_wdata;
  logic [2:0]             w_we;
  logic [COLW-1:0]        w_ram_r, w_ram_g, w_ram_b;

  // S0 registers pixels and transparency flags, S1 carries pixels beside the PROM read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pxl0 <= '0;
      r_pxl1 <= '0;
      r_opq  <= '0;
      r_hb   <= '0;
      r_vb   <= '0;
    end else if (pxl_cen) begin
      r_pxl0 <= pxl_in;
      r_pxl1 <= r_pxl0;
      for (int i = 0; i < LAYERS; i++) r_opq[i] <= (pxl_in[i*PXLW +: TRW] != TRANSP);
      r_hb <= {r_hb[LATENCY-3:0], lhbl};
      r_vb <= {r_vb[LATENCY-3:0], lvbl};
    end
  end

  generate
    if (TOPW > 0) begin : g_prom_top
      assign w_prom_addr = {r_opq, r_pxl0[LAYERS*PXLW-1 -: TOPW]};
    end else begin : g_prom_opq
      assign w_prom_addr = r_opq;
    end
  endgenerate

  jtframe_prom #(.aw(PRIOAW), .dw(LW)) u_prio (
    .clk         (clk),
    .i_cen       (pxl_cen),
    .i_rd_addr   (w_prom_addr),
    .o_q         (w_sel),
    .i_prog_addr (prog_addr),
    .i_prog_data (prog_din),
    .i_prog_we   (prom_prio_we)
  );

  // A PROM code naming no existing layer selects no pixel and is blanked later
  always_comb begin
    w_pix = '0;
    w_bad = 1'b1;
    for (int i = 0; i < LAYERS; i++) begin
      if (w_sel == LW'(i)) begin
        w_pix = r_pxl1[i*PXLW +: PXLW];
        w_bad = 1'b0;
      end
    end
  end

  // Pixel reads own the RAM port on enabled ticks; buffered writes use the gaps
  assign w_ram_addr = pxl_cen ? {w_sel, w_pix} : w_waddr;

  jtframe_colmix_wrbuf #(.AW(PALAW), .DW(COLW)) u_wrbuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_cs      (pal_cs),
    .i_wr      (cpu_wr),
    .i_addr    (cpu_addr),
    .i_din     (cpu_dout[COLW-1:0]),
    .i_pxl_cen (pxl_cen),
    .o_busy    (pal_busy),
    .o_we      (w_we),
    .o_waddr   (w_waddr),
    .o_wdata   (w_wdata)
  );

  generate
    if (COLW < 8) begin : g_dout_hi
      logic w_unused_dout;
      assign w_unused_dout = ^cpu_dout[7:COLW];
    end
  endgenerate

  jtframe_ram #(.aw(PALAW), .dw(COLW)) u_pal_r (
    .clk (clk), .i_cen (pxl_cen), .i_addr (w_ram_addr),
    .i_data (w_wdata), .i_we (w_we[0]), .o_q (w_ram_r)
  );

  jtframe_ram #(.aw(PALAW), .dw(COLW)) u_pal_g (
    .clk (clk), .i_cen (pxl_cen), .i_addr (w_ram_addr),
    .i_data (w_wdata), .i_we (w_we[1]), .o_q (w_ram_g)
  );

  jtframe_ram #(.aw(PALAW), .dw(COLW)) u_pal_b (
    .clk (clk), .i_cen (pxl_cen), .i_addr (w_ram_addr),
    .i_data (w_wdata), .i_we (w_we[2]), .o_q (w_ram_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bad3     <= 1'b0;
      r_red      <= '0;
      r_green    <= '0;
      r_blue     <= '0;
      r_lhbl_dly <= 1'b0;
      r_lvbl_dly <= 1'b0;
    end else if (pxl_cen) begin
      r_bad3     <= w_bad;
      r_lhbl_dly <= r_hb[LATENCY-2];
      r_lvbl_dly <= r_vb[LATENCY-2];
      if (!r_hb[LATENCY-2] || !r_vb[LATENCY-2] || r_bad3) begin
        r_red   <= '0;
        r_green <= '0;
        r_blue  <= '0;
      end else begin
        r_red   <= w_ram_r;
        r_green <= w_ram_g;
        r_blue  <= w_ram_b;
      end
    end
  end

  assign red      = r_red;
  assign green    = r_green;
  assign blue     = r_blue;
  assign lhbl_dly = r_lhbl_dly;
  assign lvbl_dly = r_lvbl_dly;

endmodule

// File: tb/tb_jtdd_colmix_nlayer.sv
// Bench for the colour mixer: a 4-layer and a 3-layer instance share all
// stimulus; a behavioural model predicts every output tick.
module tb_jtdd_colmix_nlayer;

  logic        clk, rst_n, pxl_cen, lhbl, lvbl;
  logic [27:0] pxl_in;
  logic [7:0]  cpu_dout;
  logic [10:0] cpu_addr;
  logic        pal_cs, cpu_wr, prom_prio_we;
  logic [7:0]  prog_addr;
  logic [1:0]  prog_din;
  logic        pal_busy, pal_busy3;
  logic [3:0]  red, green, blue, red3, green3, blue3;
  logic        lhbl_dly, lvbl_dly, lhbl_dly3, lvbl_dly3;
  logic        cen_force;

  int n_cmp = 0;
  int n_err = 0;
  int cen_cnt = 0;
  int last_wr_cnt = 0;

  logic [1:0] prom_m [256];
  logic [3:0] pal_m [3][512];

  typedef struct packed {
    int          cnt;
    logic [27:0] p;
    logic        lh;
    logic        lv;
  } item_t;
  item_t in_q[$];

  jtdd_colmix_nlayer dut (
    .clk (clk), .rst_n (rst_n), .pxl_cen (pxl_cen), .lhbl (lhbl), .lvbl (lvbl),
    .pxl_in (pxl_in), .cpu_dout (cpu_dout), .cpu_addr (cpu_addr), .pal_cs (pal_cs),
    .cpu_wr (cpu_wr), .pal_busy (pal_busy), .prog_addr (prog_addr), .prog_din (prog_din),
    .prom_prio_we (prom_prio_we), .red (red), .green (green), .blue (blue),
    .lhbl_dly (lhbl_dly), .lvbl_dly (lvbl_dly)
  );

  jtdd_colmix_nlayer #(.LAYERS(3)) dut3 (
    .clk (clk), .rst_n (rst_n), .pxl_cen (pxl_cen), .lhbl (lhbl), .lvbl (lvbl),
    .pxl_in (pxl_in[20:0]), .cpu_dout (cpu_dout), .cpu_addr (cpu_addr), .pal_cs (pal_cs),
    .cpu_wr (cpu_wr), .pal_busy (pal_busy3), .prog_addr (prog_addr), .prog_din (prog_din),
    .prom_prio_we (prom_prio_we), .red (red3), .green (green3), .blue (blue3),
    .lhbl_dly (lhbl_dly3), .lvbl_dly (lvbl_dly3)
  );

  // ---------------- clock / reset / pixel enable ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    pxl_cen = 1'b0;
    forever begin
      @(negedge clk);
      pxl_cen = cen_force ? 1'b1 : ~pxl_cen;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: run time exceeded, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- model ----------------
  // Returns {lhbl_dly, lvbl_dly, R, G, B} for one pixel of an nl-layer mixer.
  function automatic logic [13:0] model(input int nl, input logic [27:0] p,
                                        input logic lh, input logic lv);
    logic [6:0] px [4];
    logic [7:0] opq;
    int         top_w, a, sel, pa;
    for (int i = 0; i < 4; i++) px[i] = p[i*7 +: 7];
    if (!(lh && lv)) return {lh, lv, 12'h000};
    opq = 8'h00;
    for (int i = 0; i < nl; i++) opq[i] = (px[i][3:0] != 4'hF);
    top_w = 8 - nl;
    a = int'(opq) * (1 << top_w) + int'(px[nl-1] >> (7 - top_w));
    sel = int'(prom_m[a]);
    if (sel >= nl) return {2'b11, 12'h000};
    pa = sel * 128 + int'(px[sel]);
    return {2'b11, pal_m[0][pa], pal_m[1][pa], pal_m[2][pa]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard: checks every clock ----------------
  initial begin
    logic [13:0] e4, e3;
    item_t it;
    logic chk;
    e4 = '0; e3 = '0; chk = 1'b1;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        in_q.delete();
        it = '{cnt: 0, p: 28'h0, lh: 1'b0, lv: 1'b0};
        for (int i = 0; i < 3; i++) in_q.push_back(it);
        e4 = '0; e3 = '0; chk = 1'b1;
      end else if (pxl_cen) begin
        cen_cnt++;
        it = '{cnt: cen_cnt, p: pxl_in, lh: lhbl, lv: lvbl};
        in_q.push_back(it);
        it = in_q.pop_front();
        chk = !(it.lh && it.lv && it.cnt <= last_wr_cnt);
        e4 = model(4, it.p, it.lh, it.lv);
        e3 = model(3, it.p, it.lh, it.lv);
      end
      #1;
      if (chk) begin
        check("rgb4",   {20'h0, red, green, blue},    {20'h0, e4[11:0]});
        check("blank4", {30'h0, lhbl_dly, lvbl_dly},  {30'h0, e4[13:12]});
        check("rgb3",   {20'h0, red3, green3, blue3}, {20'h0, e3[11:0]});
        check("blank3", {30'h0, lhbl_dly3, lvbl_dly3}, {30'h0, e3[13:12]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [27:0] pk(input logic [6:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic feed(input logic [27:0] p, input logic lh, input logic lv);
    @(negedge clk);
    pxl_in = p; lhbl = lh; lvbl = lv;
    @(posedge clk);
    while (!pxl_cen) @(posedge clk);
  endtask

  task automatic feed4_check(input logic [27:0] p, input string name,
                             input logic [11:0] exp4, input logic [11:0] exp3);
    for (int i = 0; i < 4; i++) feed(p, 1'b1, 1'b1);
    #1;
    check({name, "_4"}, {20'h0, red, green, blue},    {20'h0, exp4});
    check({name, "_3"}, {20'h0, red3, green3, blue3}, {20'h0, exp3});
  endtask

  task automatic prom_write(input logic [7:0] a, input logic [1:0] d);
    @(negedge clk);
    prog_addr = a; prog_din = d; prom_prio_we = 1'b1;
    @(negedge clk);
    prom_prio_we = 1'b0;
    prom_m[a] = d;
    last_wr_cnt = cen_cnt;
  endtask

  task automatic strobe(input logic [1:0] bank, input logic [8:0] ent, input logic [3:0] d);
    @(negedge clk);
    cpu_addr = {bank, ent}; cpu_dout = {4'($urandom_range(0, 15)), d};
    pal_cs = 1'b1; cpu_wr = 1'b1;
    @(posedge clk);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((pal_busy || pal_busy3) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check({name, "_busy_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic pal_write(input logic [1:0] bank, input logic [8:0] ent, input logic [3:0] d);
    strobe(bank, ent, d);
    @(negedge clk);
    pal_cs = 1'b0; cpu_wr = 1'b0;
    wait_idle("pal_write");
    pal_m[bank][ent] = d;
    last_wr_cnt = cen_cnt;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; cen_force = 1'b0;
    lhbl = 1'b0; lvbl = 1'b0; pxl_in = '0;
    cpu_dout = '0; cpu_addr = '0; pal_cs = 1'b0; cpu_wr = 1'b0;
    prog_addr = '0; prog_din = '0; prom_prio_we = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("reset_rgb",  {20'h0, red, green, blue}, 32'h0);
    check("reset_busy", {31'h0, pal_busy},         32'h0);
    check("reset_dly",  {30'h0, lhbl_dly, lvbl_dly}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int a = 0; a < 256; a++) prom_write(8'(a), 2'($urandom_range(0, 3)));
    for (int b = 0; b < 3; b++)
      for (int e = 0; e < 512; e++) pal_write(2'(b), 9'(e), 4'($urandom_range(0, 15)));

    // random pixel stream, model-checked
    for (int i = 0; i < 200; i++)
      feed(28'($urandom), ($urandom_range(0, 9) != 0), ($urandom_range(0, 19) != 0));

    // priority: layers 0,1 opaque; 4-layer PROM picks layer 1, 3-layer picks invalid 3
    prom_write(8'h31, 2'd1);
    prom_write(8'h7F, 2'd3);
    pal_write(2'd0, 9'h092, 4'h6);
    pal_write(2'd1, 9'h092, 4'h7);
    pal_write(2'd2, 9'h092, 4'h8);
    feed(pk(7'h05, 7'h12, 7'h7F, 7'h0F), 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) feed(pk(7'h0F, 7'h0F, 7'h0F, 7'h0F), 1'b1, 1'b1);
    #1;
    check("prio_4", {20'h0, red, green, blue},    32'h678);
    check("prio_3", {20'h0, red3, green3, blue3}, 32'h000);

    // all layers transparent: PROM still decides
    prom_write(8'h01, 2'd0);
    prom_write(8'h03, 2'd0);
    pal_write(2'd0, 9'h00F, 4'h3);
    pal_write(2'd1, 9'h00F, 4'h5);
    pal_write(2'd2, 9'h00F, 4'h9);
    feed4_check(pk(7'h0F, 7'h0F, 7'h0F, 7'h0F), "transp", 12'h359, 12'h359);

    // posted write held off by a constant pixel enable; second strobe dropped
    prom_write(8'h11, 2'd0);
    prom_write(8'h23, 2'd0);
    cen_force = 1'b1;
    strobe(2'd0, 9'h040, 4'hA);
    #1;
    check("busy_set", {30'h0, pal_busy, pal_busy3}, 32'h3);
    @(negedge clk);
    pal_cs = 1'b0; cpu_wr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("busy_stall", {30'h0, pal_busy, pal_busy3}, 32'h3);
    strobe(2'd0, 9'h040, 4'h5);
    @(negedge clk);
    pal_cs = 1'b0; cpu_wr = 1'b0;
    cen_force = 1'b0;
    wait_idle("posted");
    pal_m[0][9'h040] = 4'hA;
    last_wr_cnt = cen_cnt;
    repeat (3) @(posedge clk);
    #1;
    check("busy_clear", {30'h0, pal_busy, pal_busy3}, 32'h0);
    for (int i = 0; i < 4; i++) feed(pk(7'h40, 7'h0F, 7'h0F, 7'h0F), 1'b1, 1'b1);
    #1;
    check("posted_r4", {28'h0, red},  32'hA);
    check("posted_r3", {28'h0, red3}, 32'hA);

    // one-tick horizontal blank appears exactly four ticks later for one tick
    feed(pk(7'h40, 7'h0F, 7'h0F, 7'h0F), 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) feed(pk(7'h40, 7'h0F, 7'h0F, 7'h0F), 1'b1, 1'b1);
    #1;
    check("hblank_dly", {30'h0, lhbl_dly, lvbl_dly}, 32'h1);
    check("hblank_rgb", {20'h0, red, green, blue},  32'h0);
    feed(pk(7'h40, 7'h0F, 7'h0F, 7'h0F), 1'b1, 1'b1);
    #1;
    check("hblank_end", {30'h0, lhbl_dly, lvbl_dly}, 32'h3);
    check("hblank_red", {28'h0, red}, 32'hA);

    // bank 3 strobe is discarded
    strobe(2'd3, 9'h040, 4'h3);
    #1;
    check("bank3_busy", {30'h0, pal_busy, pal_busy3}, 32'h0);
    @(negedge clk);
    pal_cs = 1'b0; cpu_wr = 1'b0;
    for (int i = 0; i < 4; i++) feed(pk(7'h40, 7'h0F, 7'h0F, 7'h0F), 1'b1, 1'b1);
    #1;
    check("bank3_red", {28'h0, red}, 32'hA);

    // reset mid-frame drops the pending write
    cen_force = 1'b1;
    strobe(2'd0, 9'h040, 4'h7);
    #1;
    check("rst_pend_busy", {31'h0, pal_busy}, 32'h1);
    @(negedge clk);
    pal_cs = 1'b0; cpu_wr = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_mid_rgb",  {20'h0, red, green, blue}, 32'h0);
    check("rst_mid_busy", {30'h0, pal_busy, pal_busy3}, 32'h0);
    check("rst_mid_dly",  {30'h0, lhbl_dly, lvbl_dly}, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cen_force = 1'b0;
    for (int i = 0; i < 4; i++) feed(pk(7'h40, 7'h0F, 7'h0F, 7'h0F), 1'b1, 1'b1);
    #1;
    check("rst_drop_red", {28'h0, red}, 32'hA);
    pal_write(2'd0, 9'h040, 4'hC);
    for (int i = 0; i < 4; i++) feed(pk(7'h40, 7'h0F, 7'h0F, 7'h0F), 1'b1, 1'b1);
    #1;
    check("rst_after_red", {28'h0, red}, 32'hC);

    // more random traffic after all directed changes
    for (int i = 0; i < 100; i++)
      feed(28'($urandom), ($urandom_range(0, 7) != 0), 1'b1);

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
